axistream_tlast_to_length: RTL and testbench

AXISTREAM_TLAST_TO_LENGTH -- requirements
Module: axistream_tlast_to_length

---
 rtl/axistream_tlast_to_length.sv | 184 ++++++++++++++++++
 tb/tb_axistream_tlast_to_length.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axistream_tlast_to_length.sv
// axistream_tlast_to_length
// Converts a tlast-framed AXI-Stream into a length-prefixed stream. Each
// packet is fully buffered and then emitted as a header word holding the word
// count N, followed by the N payload words in arrival order. Only one packet
// is in flight at a time. A packet that reaches 2**DEPTH_LOG2 words without
// tlast is split there. The rest of the source words then form a new packet,
// and the original tlast closes that later packet.
//
// Optional feature: define AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN to add the
// 1-bit output 'overflow'. It pulses for one cycle after each forced split.
//
// Outputs come from flops computed one cycle ahead, so there are no gaps on
// the destination side. Reset also masks the handshake outputs
// combinationally, so they read 0 for as long as rst is high.
module axistream_tlast_to_length #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_tvalid,
    output logic                  src_tready,
    input  logic [DATA_WIDTH-1:0] src_tdata,
    input  logic                  src_tlast,
    output logic                  dest_tvalid,
    input  logic                  dest_tready,
    output logic [DATA_WIDTH-1:0] dest_tdata
`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
    ,
    output logic                  overflow
`endif
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HEADER = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_n;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         rd_ptr_n;
    logic                  src_tready_q;
    logic                  src_tready_n;
    logic                  dest_tvalid_q;
    logic                  dest_tvalid_n;
    logic [DATA_WIDTH-1:0] dest_tdata_q;
    logic [DATA_WIDTH-1:0] dest_tdata_n;

    logic [DATA_WIDTH-1:0] buffer [DEPTH];

    logic                  src_fire_c;
    logic                  dest_fire_c;
    logic [CW-1:0]         count_inc_c;
    logic [CW-1:0]         rd_next_c;
    logic                  full_c;
    logic                  last_word_c;

`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
    logic                  overflow_q;
    logic                  overflow_n;
`endif

    // Reset masks the handshake and data outputs immediately
    assign src_tready  = src_tready_q & ~rst;
    assign dest_tvalid = dest_tvalid_q & ~rst;
    assign dest_tdata  = rst ? '0 : dest_tdata_q;

`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
    assign overflow    = overflow_q & ~rst;
`endif

    // Handshake and pointer helpers
    assign src_fire_c  = src_tvalid & src_tready;
    assign dest_fire_c = dest_tvalid & dest_tready;
    assign count_inc_c = count + CW'(1);
    assign rd_next_c   = rd_ptr + CW'(1);
    assign full_c      = (count_inc_c == CW'(DEPTH));
    assign last_word_c = (rd_next_c == count);

    // Next-state and next-output logic
    always_comb begin
        state_n       = state;
        count_n       = count;
        rd_ptr_n      = rd_ptr;
        src_tready_n  = src_tready_q;
        dest_tvalid_n = dest_tvalid_q;
        dest_tdata_n  = dest_tdata_q;
`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
        overflow_n    = 1'b0;
`endif
        case (state)
            FILL: begin
                if (src_fire_c) begin
                    count_n = count_inc_c;
                    if (src_tlast || full_c) begin
                        state_n       = HEADER;
                        src_tready_n  = 1'b0;
                        dest_tvalid_n = 1'b1;
                        dest_tdata_n  = DATA_WIDTH'(count_inc_c);
                    end
`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
                    overflow_n = full_c & ~src_tlast;
`endif
                end
            end
            HEADER: begin
                if (dest_fire_c) begin
                    state_n      = DRAIN;
                    rd_ptr_n     = '0;
                    dest_tdata_n = buffer[0];
                end
            end
            DRAIN: begin
                if (dest_fire_c) begin
                    if (last_word_c) begin
                        state_n       = FILL;
                        count_n       = '0;
                        rd_ptr_n      = '0;
                        src_tready_n  = 1'b1;
                        dest_tvalid_n = 1'b0;
                        dest_tdata_n  = '0;
                    end else begin
                        rd_ptr_n     = rd_next_c;
                        dest_tdata_n = buffer[rd_next_c[AW-1:0]];
                    end
                end
            end
            default: begin
                state_n       = FILL;
                count_n       = '0;
                rd_ptr_n      = '0;
                src_tready_n  = 1'b1;
                dest_tvalid_n = 1'b0;
                dest_tdata_n  = '0;
            end
        endcase
    end

    // State, pointer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL;
            count         <= '0;
            rd_ptr        <= '0;
            src_tready_q  <= 1'b1;
            dest_tvalid_q <= 1'b0;
            dest_tdata_q  <= '0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            rd_ptr        <= rd_ptr_n;
            src_tready_q  <= src_tready_n;
            dest_tvalid_q <= dest_tvalid_n;
            dest_tdata_q  <= dest_tdata_n;
        end
    end

`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
    // One-cycle pulse after a packet is split at full depth
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_n;
        end
    end
`endif

    // Packet buffer write; no reset, stale contents are never read
    always_ff @(posedge clk) begin
        if (src_fire_c) begin
            buffer[count[AW-1:0]] <= src_tdata;
        end
    end

endmodule

// File: tb/tb_axistream_tlast_to_length.sv
// Self-checking bench for axistream_tlast_to_length (default parameters).
// A cycle-by-cycle vector table covers the basic timing. Hand-written
// sequences cover the forced split, random backpressure and reset during DRAIN.
module tb_axistream_tlast_to_length;

    logic       clk;
    logic       rst;
    logic       src_tvalid;
    logic       src_tready;
    logic [7:0] src_tdata;
    logic       src_tlast;
    logic       dest_tvalid;
    logic       dest_tready;
    logic [7:0] dest_tdata;
`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
    logic       overflow;
    int         ovf_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    axistream_tlast_to_length #(
        .DATA_WIDTH(8),
        .DEPTH_LOG2(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_tvalid (src_tvalid),
        .src_tready (src_tready),
        .src_tdata  (src_tdata),
        .src_tlast  (src_tlast),
        .dest_tvalid(dest_tvalid),
        .dest_tready(dest_tready),
        .dest_tdata (dest_tdata)
`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       last;
        logic       rdy;
        logic       exp_trdy;
        logic       exp_dvld;
        logic [7:0] exp_ddata;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Collects dest handshakes and checks that a stalled output holds
    always @(negedge clk) begin
        #3;
        if (prev_stall) begin
            checks++;
            if (!dest_tvalid || dest_tdata !== prev_data) begin
                errors++;
                $display("FAIL stall_hold: got vld=%0b data=%0h expected vld=1 data=%0h at %0t",
                         dest_tvalid, dest_tdata, prev_data, $time);
            end
        end
        prev_stall = dest_tvalid && !dest_tready && !rst;
        prev_data  = dest_tdata;
        if (dest_tvalid && dest_tready) q.push_back(dest_tdata);
`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
        if (overflow) ovf_cnt++;
`endif
    end

    // Call just after a negedge; returns at negedge+1 before the accepting edge
    task automatic send_word(input logic [7:0] d, input logic l);
        int t = 0;
        src_tvalid = 1'b1;
        src_tdata  = d;
        src_tlast  = l;
        #1;
        while (!src_tready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL src_timeout: got no src_tready expected handshake for %0h", d);
        end
    endtask

    task automatic wait_q(input int n);
        int t = 0;
        while (q.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic chk_seq(input string name, input logic [7:0] e[$]);
        chk({name, "_len"}, 32'(q.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < q.size()) chk($sformatf("%s_w%0d", name, i), 32'(q[i]), 32'(e[i]));
        end
    endtask

    initial begin
        logic [7:0] e[$];

        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33};
        vecs[7]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 8'h5B, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[13] = '{1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02};
        vecs[14] = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02};
        vecs[15] = '{1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[16] = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A};
        vecs[17] = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5B};
        vecs[18] = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hEE};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

        rst         = 1'b1;
        src_tvalid  = 1'b0;
        src_tdata   = 8'h00;
        src_tlast   = 1'b0;
        dest_tready = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_src_tready", 32'(src_tready), 32'd0);
        chk("rst_dest_tvalid", 32'(dest_tvalid), 32'd0);
        chk("rst_dest_tdata", 32'(dest_tdata), 32'd0);
`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Cycle-accurate vector table
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            src_tvalid  = vecs[i].vld;
            src_tdata   = vecs[i].data;
            src_tlast   = vecs[i].last;
            dest_tready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_src_tready", i), 32'(src_tready), 32'(vecs[i].exp_trdy));
            chk($sformatf("v%0d_dest_tvalid", i), 32'(dest_tvalid), 32'(vecs[i].exp_dvld));
            chk($sformatf("v%0d_dest_tdata", i), 32'(dest_tdata), 32'(vecs[i].exp_ddata));
        end

        // 17-word packet: forced split after 16 words
        @(negedge clk);
        src_tvalid  = 1'b0;
        dest_tready = 1'b1;
        q.delete();
`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
        ovf_cnt = 0;
`endif
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            send_word(8'(i), 1'b0);
        end
`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
        @(negedge clk);
        #1;
        chk("ovf_pulse", 32'(overflow), 32'd1);
`endif
        @(negedge clk);
        send_word(8'h10, 1'b1);
        @(negedge clk);
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
        wait_q(19);
        e.delete();
        e.push_back(8'h10);
        for (int i = 0; i < 16; i++) e.push_back(8'(i));
        e.push_back(8'h01);
        e.push_back(8'h10);
        chk_seq("split", e);
`ifdef AXISTREAM_TLAST_TO_LENGTH_OVERFLOW_EN
        chk("ovf_count", 32'(ovf_cnt), 32'd1);
`endif

        // 5-word packet under random backpressure
        q.delete();
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    send_word(8'hC0 + 8'(i), (i == 4));
                end
                @(negedge clk);
                src_tvalid = 1'b0;
                src_tlast  = 1'b0;
            end
            begin
                int t = 0;
                while (q.size() < 6 && t < 400) begin
                    @(negedge clk);
                    dest_tready = 1'($urandom_range(0, 1));
                    t++;
                end
            end
        join
        @(negedge clk);
        dest_tready = 1'b1;
        e = '{8'h05, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        chk_seq("bp", e);

        // Reset in the middle of DRAIN, then a fresh packet
        q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            send_word(8'h31 + 8'(i), (i == 3));
        end
        @(negedge clk);
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
        wait_q(3);
        rst = 1'b1;
        #1;
        chk("mid_rst_dest_tvalid", 32'(dest_tvalid), 32'd0);
        chk("mid_rst_src_tready", 32'(src_tready), 32'd0);
        chk("mid_rst_dest_tdata", 32'(dest_tdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_src_tready", 32'(src_tready), 32'd1);
        chk("post_rst_dest_tvalid", 32'(dest_tvalid), 32'd0);
        q.delete();
        @(negedge clk);
        send_word(8'h7E, 1'b1);
        @(negedge clk);
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
        wait_q(2);
        repeat (6) @(negedge clk);
        e = '{8'h01, 8'h7E};
        chk_seq("after_rst", e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
